md_ctrl: RTL and testbench

- Sequencer for the multiply/divide unit (MDU) in the E stage of the 5-stage pipeline.
- Accepts mult/multu/div/divu from E and holds the unit busy for a fixed latency. Commits results to the HI/LO registers and serves mfhi/mflo/mthi/mtlo.
- Raises a stall request to the global STALL logic while a D-stage MDU instruction must wait.
- The stall freezes D and F and flushes E, the same as existing stalls.

---
 rtl/md_ctrl_pkg.sv | 29 ++
 rtl/md_ctrl_if.sv | 25 ++
 rtl/md_calc.sv | 38 +++
 rtl/md_ctrl.sv | 106 ++++++++++
 tb/tb_md_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared op codes, FSM states and op-class helpers for the multiply/divide sequencer.
package md_ctrl_pkg;

    typedef enum logic [3:0] {
        MdNone  = 4'd0,
        MdMult  = 4'd1,
        MdMultu = 4'd2,
        MdDiv   = 4'd3,
        MdDivu  = 4'd4,
        MdMfhi  = 4'd5,
        MdMflo  = 4'd6,
        MdMthi  = 4'd7,
        MdMtlo  = 4'd8
    } md_op_e;

    typedef enum logic {
        MdIdle = 1'b0,
        MdBusy = 1'b1
    } md_state_e;

    function automatic logic is_mult_op(md_op_e op);
        return (op == MdMult) || (op == MdMultu);
    endfunction

    function automatic logic is_div_op(md_op_e op);
        return (op == MdDiv) || (op == MdDivu);
    endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// E/D-stage side of the MDU: op and operands in, handshake, HI/LO and read data out.
interface md_ctrl_if;

    logic [3:0]  E_mdop;
    logic [31:0] E_a;
    logic [31:0] E_b;
    logic        D_md_use;
    logic        start;
    logic        busy;
    logic        md_stall;
    logic [31:0] E_mdout;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output E_mdop, E_a, E_b, D_md_use,
        input  start, busy, md_stall, E_mdout, hi, lo
    );

    modport slave (
        input  E_mdop, E_a, E_b, D_md_use,
        output start, busy, md_stall, E_mdout, hi, lo
    );

endinterface

// File: rtl/md_calc.sv
// Combinational MDU datapath: 64-bit {hi,lo} result of mult/multu/div/divu and a divide-by-zero flag.
module md_calc
    import md_ctrl_pkg::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o,
    output logic        div_by_zero_o
);

    logic        sgn;
    logic [31:0] n_mag, d_mag, d_safe, q_mag, r_mag, q, r;

    // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN without overflow.
    always_comb begin
        sgn    = (op_i == MdDiv);
        n_mag  = (sgn && a_i[31]) ? -a_i : a_i;
        d_mag  = (sgn && b_i[31]) ? -b_i : b_i;
        d_safe = (b_i == 32'd0) ? 32'd1 : d_mag;
        q_mag  = n_mag / d_safe;
        r_mag  = n_mag % d_safe;
        q      = (sgn && (a_i[31] ^ b_i[31])) ? -q_mag : q_mag;
        r      = (sgn && a_i[31]) ? -r_mag : r_mag;
    end

    always_comb begin
        res_o = 64'd0;
        case (op_i)
            MdMult:         res_o = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
            MdMultu:        res_o = {32'd0, a_i} * {32'd0, b_i};
            MdDiv, MdDivu:  res_o = {r, q};
            default:        res_o = 64'd0;
        endcase
        div_by_zero_o = is_div_op(op_i) && (b_i == 32'd0);
    end

endmodule

// File: rtl/md_ctrl.sv
// MDU sequencer: holds the unit busy for a fixed latency, commits to HI/LO, serves mf/mt ops.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_ctrl_if.slave   md
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    md_op_e          op;
    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     res_q, res_d;
    logic            dbz_q, dbz_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [63:0]     calc_res;
    logic            calc_dbz;
    logic            start;

    assign op = md_op_e'(md.E_mdop);

    md_calc u_calc (
        .op_i          (op),
        .a_i           (md.E_a),
        .b_i           (md.E_b),
        .res_o         (calc_res),
        .div_by_zero_o (calc_dbz)
    );

    assign start       = (is_mult_op(op) || is_div_op(op)) && (state_q == MdIdle);
    assign md.start    = start;
    assign md.busy     = (state_q == MdBusy);
    assign md.md_stall = md.D_md_use && (start || (state_q == MdBusy));
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

    always_comb begin
        md.E_mdout = 32'd0;
        case (op)
            MdMfhi:  md.E_mdout = hi_q;
            MdMflo:  md.E_mdout = lo_q;
            default: md.E_mdout = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MdIdle: begin
                if (start) begin
                    state_d = MdBusy;
                    res_d   = calc_res;
                    dbz_d   = calc_dbz;
                    cnt_d   = is_mult_op(op) ? CntW'(MULT_CYCLES - 1) : CntW'(DIV_CYCLES - 1);
                end else if (op == MdMthi) begin
                    hi_d = md.E_a;
                end else if (op == MdMtlo) begin
                    lo_d = md.E_a;
                end
            end
            MdBusy: begin
                if (cnt_q == '0) begin
                    state_d = MdIdle;
                    // A zero divisor burns the full latency but leaves HI/LO as they were.
                    if (!dbz_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = MdIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
            res_q   <= 64'd0;
            dbz_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios plus random ops against an arithmetic model.
module tb_md_ctrl;
    import md_ctrl_pkg::*;

    localparam int unsigned MultN = 5;
    localparam int unsigned DivN  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_ctrl_if bus ();

    md_ctrl #(
        .MULT_CYCLES (MultN),
        .DIV_CYCLES  (DivN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Reference: plain 64-bit arithmetic on the architectural rules.
    function automatic void ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     inout logic [31:0] hi, inout logic [31:0] lo);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        logic [63:0]     p;
        logic [63:0]     q;
        logic [63:0]     r;
        if (op == MdMult) begin
            p = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (op == MdMultu) begin
            p = ua * ub;
            hi = p[63:32];
            lo = p[31:0];
        end else if (op == MdDiv && b != 32'd0) begin
            q = sa / sb;
            r = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end else if (op == MdDivu && b != 32'd0) begin
            q = ua / ub;
            r = ua % ub;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dmu, input bit poke);
        int unsigned n = (op == MdMult || op == MdMultu) ? MultN : DivN;
        logic [31:0] old_hi = m_hi;
        logic [31:0] old_lo = m_lo;
        bus.E_mdop   = op;
        bus.E_a      = a;
        bus.E_b      = b;
        bus.D_md_use = dmu;
        settle();
        chk("start_cycle_start", {31'd0, bus.start}, 32'd1);
        chk("start_cycle_busy", {31'd0, bus.busy}, 32'd0);
        chk("start_cycle_stall", {31'd0, bus.md_stall}, {31'd0, dmu});
        ref_calc(op, a, b, m_hi, m_lo);
        tick();
        for (int i = 1; i <= int'(n); i++) begin
            // A stray MDU op while busy must have no effect.
            bus.E_mdop = (poke && i == 2) ? 4'($urandom_range(1, 8)) : 4'(MdNone);
            bus.E_a    = $urandom;
            bus.E_b    = $urandom;
            settle();
            chk("busy_high", {31'd0, bus.busy}, 32'd1);
            chk("busy_start_low", {31'd0, bus.start}, 32'd0);
            chk("busy_stall", {31'd0, bus.md_stall}, {31'd0, dmu});
            chk("busy_hi_held", bus.hi, old_hi);
            chk("busy_lo_held", bus.lo, old_lo);
            tick();
        end
        bus.E_mdop = MdNone;
        settle();
        chk("done_busy_low", {31'd0, bus.busy}, 32'd0);
        chk("done_stall_low", {31'd0, bus.md_stall}, 32'd0);
        chk("done_hi", bus.hi, m_hi);
        chk("done_lo", bus.lo, m_lo);
        bus.D_md_use = 1'b0;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] a);
        bus.E_mdop = op;
        bus.E_a    = a;
        settle();
        chk("mt_no_start", {31'd0, bus.start}, 32'd0);
        tick();
        if (op == MdMthi) m_hi = a;
        else              m_lo = a;
        bus.E_mdop = MdNone;
    endtask

    task automatic read_check(input logic [3:0] op);
        bus.E_mdop = op;
        settle();
        chk(op == MdMfhi ? "mfhi_read" : "mflo_read", bus.E_mdout, op == MdMfhi ? m_hi : m_lo);
        tick();
        bus.E_mdop = MdNone;
    endtask

    initial begin
        bus.E_mdop   = MdNone;
        bus.E_a      = 32'd0;
        bus.E_b      = 32'd0;
        bus.D_md_use = 1'b0;

        // Reset for two cycles, then check the cleared state.
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        settle();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_start", {31'd0, bus.start}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        bus.E_mdop = MdMfhi;
        settle();
        chk("rst_mfhi", bus.E_mdout, 32'd0);
        bus.E_mdop = MdNone;
        tick();

        // Directed cases; also pin the expected values as literals.
        run_op(MdMult, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        chk("mult_hi_lit", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo_lit", bus.lo, 32'hFFFF_FFF1);
        tick();
        run_op(MdDivu, 32'd100, 32'd7, 1'b0, 1'b0);
        chk("divu_hi_lit", bus.hi, 32'd2);
        chk("divu_lo_lit", bus.lo, 32'd14);
        tick();
        run_op(MdDiv, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        chk("div_hi_lit", bus.hi, 32'hFFFF_FFFF);
        chk("div_lo_lit", bus.lo, 32'hFFFF_FFFD);
        tick();
        move_to(MdMthi, 32'h1234);
        move_to(MdMtlo, 32'h5678);
        read_check(MdMfhi);
        read_check(MdMflo);
        run_op(MdDiv, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        chk("dbz_hi_lit", bus.hi, 32'h1234);
        chk("dbz_lo_lit", bus.lo, 32'h5678);
        tick();
        run_op(MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        chk("ovf_hi_lit", bus.hi, 32'd0);
        chk("ovf_lo_lit", bus.lo, 32'h8000_0000);
        tick();

        // Randomized ops with occasional mt/mf traffic in between.
        for (int k = 0; k < 30; k++) begin
            logic [3:0]  op = 4'($urandom_range(1, 4));
            logic [31:0] a  = $urandom;
            logic [31:0] b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 3) == 0) move_to($urandom_range(0, 1) ? MdMthi : MdMtlo, $urandom);
            run_op(op, a, b, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            read_check($urandom_range(0, 1) ? MdMfhi : MdMflo);
        end

        // Reset in busy cycle 4 of a divide discards the result and clears HI/LO.
        move_to(MdMthi, 32'hA5A5_0001);
        move_to(MdMtlo, 32'h5A5A_0002);
        bus.E_mdop = MdDiv;
        bus.E_a    = 32'd1000;
        bus.E_b    = 32'd3;
        tick();
        bus.E_mdop = MdNone;
        tick();
        tick();
        tick();
        settle();
        chk("mid_busy_before_rst", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        settle();
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_hi", bus.hi, 32'd0);
        chk("mid_rst_lo", bus.lo, 32'd0);
        read_check(MdMflo);
        for (int i = 0; i < int'(DivN); i++) tick();
        settle();
        chk("mid_rst_lo_stays", bus.lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
